// File: rtl/fft64_twiddle_mul.sv
// Twiddle-multiply stage between the two 8-point butterfly passes of the 64-point FFT.
// Define FFT64_TWMUL_ROUND_EN to round half up before scaling; truncation (floor) otherwise.
module fft64_twiddle_mul #(
   parameter int nb = 12,
   parameter int nw = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ED,
   input  logic          START,
   input  logic [nb-1:0] DR,
   input  logic [nb-1:0] DI,
   input  logic [nw-1:0] WR,
   input  logic [nw-1:0] WI,
   output logic [5:0]    ADDR,
   output logic [nb:0]   DOR,
   output logic [nb:0]   DOI,
   output logic          RDY
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic                        state;
   logic [5:0]                  cnt;
   logic                        v0, f0;
   logic                        v1, f1, v2, f2, v3, f3;
   logic signed [nb-1:0]        dr1, di1;
   logic signed [nw-1:0]        wr1, wi1;
   logic signed [nb+nw-1:0]     prr, pii, pri, pir;
   logic signed [nb+nw:0]       re_sum, im_sum, re_adj, im_adj;
   logic [nb:0]                 re_out, im_out;

   assign ADDR = (ED & START) ? 6'd0 : cnt;
   assign v0   = ED & (START | (state == RUN));
   assign f0   = ED & START;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (ED) begin
         if (START) begin
            state <= RUN;
            cnt   <= 6'd1;
         end else if (state == RUN) begin
            if (cnt == 6'd63) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 6'd1;
            end
         end
      end
   end

   always_comb begin
      re_sum = prr - pii;
      im_sum = pri + pir;
`ifdef FFT64_TWMUL_ROUND_EN
      re_adj = re_sum + $signed({{(nb+2){1'b0}}, 1'b1, {(nw-2){1'b0}}});
      im_adj = im_sum + $signed({{(nb+2){1'b0}}, 1'b1, {(nw-2){1'b0}}});
`else
      re_adj = re_sum;
      im_adj = im_sum;
`endif
      re_out = (nb+1)'(re_adj >>> (nw-1));
      im_out = (nb+1)'(im_adj >>> (nw-1));
   end

   // v3/f3 travel with DOR/DOI, so RDY qualifies the value currently on the outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         dr1 <= '0;
         di1 <= '0;
         wr1 <= '0;
         wi1 <= '0;
         v1  <= 1'b0;
         f1  <= 1'b0;
         prr <= '0;
         pii <= '0;
         pri <= '0;
         pir <= '0;
         v2  <= 1'b0;
         f2  <= 1'b0;
         v3  <= 1'b0;
         f3  <= 1'b0;
         DOR <= '0;
         DOI <= '0;
      end else if (ED) begin
         dr1 <= DR;
         di1 <= DI;
         wr1 <= WR;
         wi1 <= WI;
         v1  <= v0;
         f1  <= f0;
         prr <= dr1 * wr1;
         pii <= di1 * wi1;
         pri <= dr1 * wi1;
         pir <= di1 * wr1;
         v2  <= v1;
         f2  <= f1;
         v3  <= v2;
         f3  <= f2;
         if (v2) begin
            DOR <= re_out;
            DOI <= im_out;
         end
      end
   end

   assign RDY = ED & v3 & f3;

endmodule

// File: tb/tb_fft64_twiddle_mul.sv
// Directed bench for fft64_twiddle_mul: frame sequencing, ED gating, restart and reset.
module tb_fft64_twiddle_mul;

   logic        CLK = 1'b0;
   logic        RST, ED, START;
   logic [11:0] DR, DI;
   logic [15:0] WR, WI;
   logic [5:0]  ADDR;
   logic [12:0] DOR, DOI;
   logic        RDY;
   int          ntests = 0;
   int          nfail = 0;
   int          rdy_cnt;

   fft64_twiddle_mul #(.nb(12), .nw(16)) dut (
      .CLK(CLK), .RST(RST), .ED(ED), .START(START),
      .DR(DR), .DI(DI), .WR(WR), .WI(WI),
      .ADDR(ADDR), .DOR(DOR), .DOI(DOI), .RDY(RDY)
   );

   always #5 CLK = ~CLK;

   // Twiddle ROM: near-unity everywhere except address 16, which holds -j
   always_comb begin
      WR = 16'h7FFF;
      WI = 16'h0000;
      if (ADDR == 6'd16) begin
         WR = 16'h0000;
         WI = 16'h8001;
      end
   end

   function automatic int sdr(input int i);
      return (i == 0 || i == 16) ? 1000 : 10 * i + 5;
   endfunction

   function automatic int sdi(input int i);
      return (i == 0 || i == 16) ? 0 : -3 * i;
   endfunction

   // x * 32767 / 32768 after scaling, valid for |x| < 16384
   function automatic int tr(input int x);
`ifdef FFT64_TWMUL_ROUND_EN
      return x;
`else
      return (x > 0) ? x - 1 : x;
`endif
   endfunction

   function automatic int er(input int i);
      return (i == 16) ? 0 : tr(sdr(i));
   endfunction

   function automatic int ei(input int i);
      return (i == 16) ? -1000 : tr(sdi(i));
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic ed, input logic st, input int idx);
      @(posedge CLK);
      #1;
      RST   = rst;
      ED    = ed;
      START = st;
      DR    = 12'(sdr(idx));
      DI    = 12'(sdi(idx));
      #1;
   endtask

   initial begin
      RST = 1'b1; ED = 1'b0; START = 1'b0; DR = '0; DI = '0;
      drive(1'b1, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b0, 0);
      drive(1'b0, 1'b0, 1'b0, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_dor", $signed(DOR), 0);
      chk("rst_doi", $signed(DOI), 0);
      chk("rst_rdy", RDY, 0);

      // full frame with ED held high, then idle
      rdy_cnt = 0;
      for (int n = 0; n < 68; n++) begin
         drive(1'b0, 1'b1, (n == 0), n);
         chk("frm_addr", ADDR, (n < 64) ? n : 0);
         if (RDY === 1'b1) rdy_cnt++;
         if (n >= 3) begin
            chk("frm_dor", $signed(DOR), er((n >= 67) ? 63 : n - 3));
            chk("frm_doi", $signed(DOI), ei((n >= 67) ? 63 : n - 3));
            chk("frm_rdy", RDY, (n == 3));
         end
      end
      chk("frm_rdy_count", rdy_cnt, 1);

      // ED toggling during a frame
      drive(1'b0, 1'b1, 1'b1, 0);  chk("ed_addr0", ADDR, 0);
      drive(1'b0, 1'b0, 1'b0, 1);  chk("ed_addr1_off", ADDR, 1); chk("ed_rdy_off", RDY, 0);
      drive(1'b0, 1'b1, 1'b0, 1);  chk("ed_addr1_on", ADDR, 1);
      drive(1'b0, 1'b0, 1'b0, 2);  chk("ed_addr2_off", ADDR, 2); chk("ed_hold", $signed(DOR), er(63));
      drive(1'b0, 1'b1, 1'b0, 2);  chk("ed_addr2_on", ADDR, 2); chk("ed_hold2", $signed(DOR), er(63));
      drive(1'b0, 1'b0, 1'b0, 3);  chk("ed_addr3_off", ADDR, 3);
      chk("ed_dor0", $signed(DOR), er(0)); chk("ed_rdy_off2", RDY, 0);
      drive(1'b0, 1'b1, 1'b0, 3);  chk("ed_addr3_on", ADDR, 3);
      chk("ed_rdy_on", RDY, 1); chk("ed_dor0b", $signed(DOR), er(0));
      drive(1'b0, 1'b0, 1'b0, 4);  chk("ed_addr4_off", ADDR, 4);
      chk("ed_dor1", $signed(DOR), er(1)); chk("ed_rdy_off3", RDY, 0);
      drive(1'b0, 1'b1, 1'b0, 4);  chk("ed_rdy_on2", RDY, 0);
      chk("ed_doi1", $signed(DOI), ei(1));

      // run on to index 39, then restart at cnt 40
      for (int i = 5; i < 40; i++) begin
         drive(1'b0, 1'b1, 1'b0, i);
         chk("run_addr", ADDR, i);
         chk("run_dor", $signed(DOR), er(i - 3));
      end
      drive(1'b0, 1'b1, 1'b1, 0);
      chk("rs_addr0", ADDR, 0);
      chk("rs_dor37", $signed(DOR), er(37));
      chk("rs_rdy0", RDY, 0);
      for (int j = 1; j < 20; j++) begin
         drive(1'b0, 1'b1, 1'b0, j);
         chk("rs_addr", ADDR, j);
         chk("rs_dor", $signed(DOR), (j == 1) ? er(38) : (j == 2) ? er(39) : er(j - 3));
         chk("rs_doi", $signed(DOI), (j == 1) ? ei(38) : (j == 2) ? ei(39) : ei(j - 3));
         chk("rs_rdy", RDY, (j == 3));
      end

      // reset at cnt 20 with a full pipeline
      drive(1'b1, 1'b1, 1'b0, 20);
      chk("mr_addr20", ADDR, 20);
      drive(1'b0, 1'b1, 1'b0, 21);
      chk("mr_addr", ADDR, 0);
      chk("mr_dor", $signed(DOR), 0);
      chk("mr_doi", $signed(DOI), 0);
      chk("mr_rdy", RDY, 0);
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b1, 1'b0, 0);
         chk("mr_addr_idle", ADDR, 0);
         chk("mr_dor_idle", $signed(DOR), 0);
         chk("mr_doi_idle", $signed(DOI), 0);
         chk("mr_rdy_idle", RDY, 0);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
